// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit engines.
//   UART_DATA_BITS : payload bits per frame (8N1)
//   CLKS_PER_BIT   : default clock cycles per bit period
//   rx_state_t     : receive FSM state encoding
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int CLKS_PER_BIT   = 16;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for asynchronous inputs.
//   clk   : destination clock
//   reset : synchronous, active-high; both flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronized output, two clocks behind d
module uart_sync #(
  parameter int   WIDTH   = 1,
  parameter logic RST_VAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= {WIDTH{RST_VAL}};
      q    <= {WIDTH{RST_VAL}};
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rx_core.sv
// rx_core: 8N1 UART receiver with a one-entry valid/ready holding register.
//   rx_clk    : sole clock
//   reset     : synchronous, active-high
//   rx        : asynchronous serial line, idle high
//   rx_data   : received byte, stable while rx_valid
//   rx_valid  : holding register full
//   rx_ready  : consumer accept; transfer on rx_valid && rx_ready
//   rx_done   : 1-cycle pulse per frame with a good stop bit
//   frame_err : 1-cycle pulse when the stop bit samples low
//   overrun   : 1-cycle pulse when a good frame is dropped (register full)
module rx_core #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
  input  logic                              rx_clk,
  input  logic                              reset,
  input  logic                              rx,
  output logic [uart_pkg::UART_DATA_BITS-1:0] rx_data,
  output logic                              rx_valid,
  input  logic                              rx_ready,
  output logic                              rx_done,
  output logic                              frame_err,
  output logic                              overrun
);
  import uart_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic                      rx_s;
  rx_state_t                 state;
  logic [CW-1:0]             baud_cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  // The synchronizer flops come out of reset holding 1, not the pin. This
  // marks when both stages carry real pin samples, so a line held low
  // through reset is not mistaken for an idle line.
  logic [1:0]                fill_pipe;

  uart_sync #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .clk   (rx_clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge rx_clk) begin
    if (reset) begin
      state     <= WAIT_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      fill_pipe <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      fill_pipe <= {fill_pipe[0], 1'b1};

      // Drain on handshake; a good frame landing this cycle overrides below.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        WAIT_IDLE: if (fill_pipe[1] && rx_s) state <= IDLE;

        IDLE: begin
          baud_cnt <= '0;
          if (!rx_s) state <= START;
        end

        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;        // glitch, not a start bit
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt       <= '0;
            shreg[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            if (rx_s) begin
              state   <= IDLE;
              rx_done <= 1'b1;
              if (!rx_valid || rx_ready) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              state     <= WAIT_IDLE;
              frame_err <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rx_core.md
# rx_core

UART receive engine for the Avalon UART slave; the receive-side counterpart of `tx_core`. Recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity) from the asynchronous `rx` pin by mid-bit sampling on a fixed clocks-per-bit divider. Presents each received byte through a one-entry valid/ready holding register to the Avalon register layer. Flags framing errors and overruns.

## Interface
- `CLKS_PER_BIT`, 16: `rx_clk` cycles per bit period (N); legal range ≥ 4; H = N/2, integer division.
- `rx_clk`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial line, idle high.
- `rx_data`  out  8  received byte; stable while `rx_valid`=1.
- `rx_valid`  out  1  holding register full.
- `rx_ready`  in  1  consumer accepts; transfer on `rx_valid && rx_ready`.
- `rx_done`  out  1  one-cycle pulse per frame with valid stop bit.
- `frame_err`  out  1  one-cycle pulse when stop bit samples low.
- `overrun`  out  1  one-cycle pulse when a good frame is dropped because the holding register is full.

## Operation
- `rx` passes through a 2-flop synchronizer, giving `rx_s`. Both flops reset to 1.
- States: WAIT_IDLE, IDLE, START, DATA, STOP.
- WAIT_IDLE: entered from reset and after a framing error. Moves to IDLE on the first cycle `rx_s`=1.
- IDLE: `rx_s`=0 → START; the baud counter clears.
- START: at baud count H−1, sample `rx_s`.
  - 0 → DATA with bit index 0 and baud counter cleared.
  - 1 → IDLE (glitch rejected; no flag raised).
- DATA: every N cycles, sample `rx_s` into shift register bit[index], LSB first. After index 7 → STOP.
- STOP: after N cycles, sample `rx_s`.
  - 1 → frame good; go to IDLE.
  - 0 → pulse `frame_err`, discard the byte, go to WAIT_IDLE.
- Good frame:
  - Always pulse `rx_done`.
  - If the holding register is empty, or is being drained in the same cycle (`rx_valid && rx_ready`), load `rx_data` and keep/set `rx_valid`=1.
  - Otherwise pulse `overrun`; the old byte is kept and the new byte dropped.
- Holding register: `rx_valid` clears on handshake, unless a good frame loads in the same cycle.
- Counters:
  - Baud counter width is $clog2(N); it wraps to 0 at each sample.
  - Bit index is 3 bits.
  - No arithmetic overflow is possible beyond these.

## Timing
- Reset values: `rx_data`=8'h00, `rx_valid`=0, `rx_done`=0, `frame_err`=0, `overrun`=0. State is WAIT_IDLE.
- Reset mid-frame abandons the frame with no flags. Reception re-arms only after `rx` is seen high.
- Let k be the first cycle with `rx_s`=0 in IDLE, which is 2 cycles after `rx` falls at the pin. Samples are taken at:
  - start bit: k+H
  - data bit i: k+H+(i+1)·N
  - stop bit: k+H+9·N
- `rx_done`, `frame_err`, `overrun` and the `rx_data`/`rx_valid` update are all registered and visible at k+H+9·N+1. For N=16 this is k+153.
- Back-to-back frames: a start edge arriving immediately after the stop sample is detected in IDLE with no lost cycle.
- The outputs `rx_done`, `frame_err` and `overrun` are mutually exclusive except `rx_done`+`overrun`, which pulse together.
- `rx_ready` has no effect while `rx_valid`=0.

## Structure
- Shared package `uart_pkg`:
  - state enum `rx_state_t`
  - `UART_DATA_BITS`=8
  - default `CLKS_PER_BIT`=16
- The package is shared with `tx_core`.
- One sub-module, `uart_sync`: parameterized 2-flop synchronizer with a reset value parameter (1 here).
- FSM, counters, shift register and holding register stay in `rx_core`.

## Test plan
- Reset, then frame 0xA5 at N=16 with `rx_ready`=1.
  - Required: `rx_done` and `rx_valid` at k+153, `rx_data`=8'hA5.
  - Required: handshake the next cycle clears `rx_valid`.
- Random 10-byte stream (seed 20) driven back-to-back by a bit-accurate model, with `rx_ready`=1.
  - Required: all bytes received in order, no flags.
- `rx` low pulse lasting H−2 cycles in IDLE.
  - Required: returns to IDLE, no `rx_done`/`frame_err`, and a following 0x3C is received correctly.
- Frame 0x55 with stop bit held low for 2N cycles, then line high, then 0x0F.
  - Required: `frame_err` pulse at k+153 with `rx_valid` unchanged.
  - Required: no start detected until the line goes high; 0x0F is then received.
- `rx_ready`=0; send 0x11, then 0x22.
  - Required: `rx_data` stays 8'h11; second frame gives `rx_done`+`overrun` pulses.
  - Required: `rx_ready` pulsed on the same cycle as a third frame 0x33 completes → `rx_data`=8'h33 and `rx_valid` stays 1.
- Assert `reset` during data bit 4 with `rx` low.
  - Required: all outputs go to reset values; no start is detected until `rx` returns high; the next 0x81 frame is received correctly.
